// File: rtl/sr_cmd_pkg.sv
// rtl/sr_cmd_pkg.sv - Shared types for the S/R latch command sequencer.
package sr_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_CHECK
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_SET,
    CMD_CLR
  } cmd_t;

  localparam int PULSE_CNT_W = 4;

endpackage

// File: rtl/sr_req_sync.sv
// rtl/sr_req_sync.sv - Request synchronizer and rising-edge detect; debounce under SR_CMD_DEBOUNCE_EN.
module sr_req_sync
`ifdef SR_CMD_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_req,
  output logic o_rise
);

  logic       r_s1;
  logic       r_s2;
  logic       r_prev;
  logic [1:0] r_valid;
  logic       w_level;

  // r_prev is held high until the synchronizer has refilled, so a level
  // already asserted across reset never looks like a fresh press.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_valid <= 2'b00;
      r_prev  <= 1'b1;
    end else begin
      r_s1    <= i_req;
      r_s2    <= r_s1;
      r_valid <= {r_valid[0], 1'b1};
      r_prev  <= r_valid[1] ? w_level : 1'b1;
    end
  end

`ifdef SR_CMD_DEBOUNCE_EN
  logic       r_db;
  logic [7:0] r_db_cnt;

  // Accepted level starts high so the post-reset settle to low is not an edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_db     <= 1'b1;
      r_db_cnt <= 8'd0;
    end else if (r_s2 == r_db) begin
      r_db_cnt <= 8'd0;
    end else if (r_db_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
      r_db     <= r_s2;
      r_db_cnt <= 8'd0;
    end else begin
      r_db_cnt <= r_db_cnt + 8'd1;
    end
  end

  assign w_level = r_db;
`else
  assign w_level = r_s2;
`endif

  assign o_rise = w_level & ~r_prev & r_valid[1];

endmodule

// File: rtl/sr_cmd_sequencer.sv
// rtl/sr_cmd_sequencer.sv - S/R latch command sequencer (optional debounce: SR_CMD_DEBOUNCE_EN).
module sr_cmd_sequencer
  import sr_cmd_pkg::*;
#(
  parameter int PULSE_CYCLES    = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic set_req,
  input  logic clr_req,
  input  logic Q,
  output logic S,
  output logic R,
  output logic en,
  output logic busy,
  output logic done,
  output logic err,
  output logic conflict
);

  if (PULSE_CYCLES < 1 || PULSE_CYCLES > 15) begin : g_bad_pulse
    $error("PULSE_CYCLES must be 1..15");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be 2..255");
  end

  state_t                 r_state;
  cmd_t                   r_cmd;
  cmd_t                   r_pending;
  logic [PULSE_CNT_W-1:0] r_cnt;
  logic                   w_set_rise;
  logic                   w_clr_rise;
  logic                   w_conflict;
  logic                   w_mismatch;
  cmd_t                   w_edge_cmd;
  cmd_t                   w_launch;

  sr_req_sync
`ifdef SR_CMD_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_set_sync (.i_clk(clk), .i_reset_n(reset_n), .i_req(set_req), .o_rise(w_set_rise));

  sr_req_sync
`ifdef SR_CMD_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_clr_sync (.i_clk(clk), .i_reset_n(reset_n), .i_req(clr_req), .o_rise(w_clr_rise));

  always_comb begin
    w_edge_cmd = CMD_NONE;
    if (w_set_rise && !w_clr_rise) w_edge_cmd = CMD_SET;
    else if (w_clr_rise && !w_set_rise) w_edge_cmd = CMD_CLR;
  end

  assign w_conflict = w_set_rise & w_clr_rise;
  // A fresh edge in IDLE is newer than anything pending, so it takes priority.
  assign w_launch   = (w_edge_cmd != CMD_NONE) ? w_edge_cmd : r_pending;
  assign w_mismatch = (r_cmd == CMD_SET) ? ~Q : (r_cmd == CMD_CLR) ? Q : 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cmd     <= CMD_NONE;
      r_pending <= CMD_NONE;
      r_cnt     <= '0;
      S         <= 1'b0;
      R         <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      conflict  <= 1'b0;
    end else begin
      done     <= 1'b0;
      conflict <= w_conflict;
      case (r_state)
        ST_IDLE: begin
          if (w_launch != CMD_NONE) begin
            r_state   <= ST_SETUP;
            r_cmd     <= w_launch;
            r_pending <= CMD_NONE;
            S         <= (w_launch == CMD_SET);
            R         <= (w_launch == CMD_CLR);
            busy      <= 1'b1;
            err       <= 1'b0;
          end
        end
        ST_SETUP: begin
          r_state <= ST_PULSE;
          en      <= 1'b1;
          r_cnt   <= PULSE_CNT_W'(PULSE_CYCLES - 1);
        end
        ST_PULSE: begin
          if (r_cnt == '0) begin
            r_state <= ST_HOLD;
            en      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - PULSE_CNT_W'(1);
          end
        end
        ST_HOLD: begin
          r_state <= ST_CHECK;
          S       <= 1'b0;
          R       <= 1'b0;
          done    <= 1'b1;
        end
        ST_CHECK: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          if (w_mismatch) err <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          S       <= 1'b0;
          R       <= 1'b0;
          en      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
      if (r_state != ST_IDLE && w_edge_cmd != CMD_NONE) r_pending <= w_edge_cmd;
    end
  end

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// tb/tb_sr_cmd_sequencer.sv - Directed self-checking bench for sr_cmd_sequencer.
module tb_sr_cmd_sequencer;

`ifdef SR_CMD_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 0;
`endif
  localparam int LAT = 3 + DB;
  localparam int PW  = 2 + DB;

  logic clk = 1'b0;
  logic reset_n, set_req, clr_req;
  logic s_o, r_o, en_o, busy_o, done_o, err_o, conf_o;
  logic q_latch = 1'b0;
  logic q_tie0  = 1'b0;
  logic q, q_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   c_s = 0, c_r = 0, c_en = 0, c_done = 0, c_conf = 0, c_busy = 0, c_sr = 0;

  always #5 clk = ~clk;

  assign q   = q_tie0 ? 1'b0 : q_latch;
  assign q_n = ~q;

  sr_cmd_sequencer #(.PULSE_CYCLES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .set_req(set_req), .clr_req(clr_req), .Q(q),
    .S(s_o), .R(r_o), .en(en_o), .busy(busy_o), .done(done_o), .err(err_o), .conflict(conf_o)
  );

  always @(posedge clk) begin
    if (en_o) begin
      if (s_o) q_latch <= 1'b1;
      else if (r_o) q_latch <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (s_o) c_s++;
    if (r_o) c_r++;
    if (en_o) c_en++;
    if (done_o) c_done++;
    if (conf_o) c_conf++;
    if (busy_o) c_busy++;
    if (s_o && r_o) c_sr++;
  end

  task automatic test_reset();
    reset_n = 1'b0; set_req = 1'b0; clr_req = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (s_o !== 1'b0) begin n_fail++; $display("FAIL reset_S got %b want 0", s_o); end
    n_tests++; if (r_o !== 1'b0) begin n_fail++; $display("FAIL reset_R got %b want 0", r_o); end
    n_tests++; if (en_o !== 1'b0) begin n_fail++; $display("FAIL reset_en got %b want 0", en_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
    n_tests++; if (conf_o !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got %b want 0", conf_o); end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_set();
    int b_s, b_r, b_en, b_done;
    b_s = c_s; b_r = c_r; b_en = c_en; b_done = c_done;
    set_req = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL set_latency_early busy got %b want 0", busy_o); end
    @(posedge clk); #1;
    n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL set_latency busy got %b want 1", busy_o); end
    n_tests++; if (s_o !== 1'b1 || en_o !== 1'b0) begin n_fail++; $display("FAIL set_setup S/en got %b/%b want 1/0", s_o, en_o); end
    repeat (10 - LAT) @(negedge clk);
    set_req = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++; if (c_s - b_s != 4) begin n_fail++; $display("FAIL set_S_cycles got %0d want 4", c_s - b_s); end
    n_tests++; if (c_en - b_en != 2) begin n_fail++; $display("FAIL set_en_cycles got %0d want 2", c_en - b_en); end
    n_tests++; if (c_r - b_r != 0) begin n_fail++; $display("FAIL set_R_cycles got %0d want 0", c_r - b_r); end
    n_tests++; if (c_done - b_done != 1) begin n_fail++; $display("FAIL set_done_count got %0d want 1", c_done - b_done); end
    n_tests++; if (q !== 1'b1) begin n_fail++; $display("FAIL set_Q got %b want 1", q); end
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL set_err got %b want 0", err_o); end
  endtask

  task automatic test_clear();
    int b_s, b_r, b_en, b_done;
    b_s = c_s; b_r = c_r; b_en = c_en; b_done = c_done;
    clr_req = 1'b1;
    repeat (PW) @(negedge clk);
    clr_req = 1'b0;
    repeat (15) @(negedge clk);
    n_tests++; if (c_r - b_r != 4) begin n_fail++; $display("FAIL clr_R_cycles got %0d want 4", c_r - b_r); end
    n_tests++; if (c_s - b_s != 0) begin n_fail++; $display("FAIL clr_S_cycles got %0d want 0", c_s - b_s); end
    n_tests++; if (c_en - b_en != 2) begin n_fail++; $display("FAIL clr_en_cycles got %0d want 2", c_en - b_en); end
    n_tests++; if (c_done - b_done != 1) begin n_fail++; $display("FAIL clr_done_count got %0d want 1", c_done - b_done); end
    n_tests++; if (q !== 1'b0 || q_n !== 1'b1) begin n_fail++; $display("FAIL clr_Q_Qn got %b/%b want 0/1", q, q_n); end
  endtask

  task automatic test_conflict();
    int b_s, b_r, b_en, b_conf, b_busy;
    b_s = c_s; b_r = c_r; b_en = c_en; b_conf = c_conf; b_busy = c_busy;
    set_req = 1'b1; clr_req = 1'b1;
    repeat (PW + 1) @(negedge clk);
    set_req = 1'b0; clr_req = 1'b0;
    repeat (15) @(negedge clk);
    n_tests++; if (c_conf - b_conf != 1) begin n_fail++; $display("FAIL conflict_pulses got %0d want 1", c_conf - b_conf); end
    n_tests++; if ((c_s - b_s) + (c_r - b_r) + (c_en - b_en) != 0) begin n_fail++; $display("FAIL conflict_SRen_cycles got %0d want 0", (c_s - b_s) + (c_r - b_r) + (c_en - b_en)); end
    n_tests++; if (c_busy - b_busy != 0) begin n_fail++; $display("FAIL conflict_busy_cycles got %0d want 0", c_busy - b_busy); end
  endtask

`ifndef SR_CMD_DEBOUNCE_EN
  task automatic test_back_to_back();
    int b_s, b_r, b_done, b_en;
    b_s = c_s; b_r = c_r; b_done = c_done; b_en = c_en;
    set_req = 1'b1;
    repeat (2) @(negedge clk);
    set_req = 1'b0; clr_req = 1'b1;
    repeat (2) @(negedge clk);
    clr_req = 1'b0; set_req = 1'b1;
    repeat (2) @(negedge clk);
    set_req = 1'b0;
    repeat (25) @(negedge clk);
    n_tests++; if (c_s - b_s != 8) begin n_fail++; $display("FAIL b2b_S_cycles got %0d want 8", c_s - b_s); end
    n_tests++; if (c_r - b_r != 0) begin n_fail++; $display("FAIL b2b_R_cycles got %0d want 0", c_r - b_r); end
    n_tests++; if (c_done - b_done != 2) begin n_fail++; $display("FAIL b2b_done_count got %0d want 2", c_done - b_done); end
    n_tests++; if (c_en - b_en != 4) begin n_fail++; $display("FAIL b2b_en_cycles got %0d want 4", c_en - b_en); end
  endtask
`endif

  task automatic test_err();
    int b_done;
    q_tie0 = 1'b1;
    set_req = 1'b1;
    repeat (PW) @(negedge clk);
    set_req = 1'b0;
    repeat (15) @(negedge clk);
    n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_after_set got %b want 1", err_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL err_idle_busy got %b want 0", busy_o); end
    b_done = c_done;
    clr_req = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #1;
    n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_hold_before_setup got %b want 1", err_o); end
    @(posedge clk); #1;
    n_tests++; if (err_o !== 1'b0 || r_o !== 1'b1) begin n_fail++; $display("FAIL err_clear_at_setup err/R got %b/%b want 0/1", err_o, r_o); end
    @(negedge clk);
    clr_req = 1'b0;
    repeat (12) @(negedge clk);
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_after_good_clear got %b want 0", err_o); end
    n_tests++; if (c_done - b_done != 1) begin n_fail++; $display("FAIL err_clear_done got %0d want 1", c_done - b_done); end
    q_tie0 = 1'b0;
  endtask

  task automatic test_reset_mid_pulse();
    int b_done, b_busy, k;
    b_done = c_done;
    set_req = 1'b1;
    k = 0;
    while (en_o !== 1'b1 && k < 30) begin @(negedge clk); k++; end
    n_tests++; if (en_o !== 1'b1) begin n_fail++; $display("FAIL midpulse_wait_en got %b want 1 (timeout)", en_o); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if (en_o !== 1'b0 || busy_o !== 1'b0 || s_o !== 1'b0) begin n_fail++; $display("FAIL midpulse_async en/busy/S got %b/%b/%b want 0/0/0", en_o, busy_o, s_o); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    b_busy = c_busy;
    repeat (15) @(negedge clk);
    n_tests++; if (c_done - b_done != 0) begin n_fail++; $display("FAIL midpulse_done got %0d want 0", c_done - b_done); end
    n_tests++; if (c_busy - b_busy != 0) begin n_fail++; $display("FAIL midpulse_held_level_busy got %0d want 0", c_busy - b_busy); end
    set_req = 1'b0;
    repeat (LAT + 2) @(negedge clk);
  endtask

`ifdef SR_CMD_DEBOUNCE_EN
  task automatic test_glitch();
    int b_busy;
    b_busy = c_busy;
    set_req = 1'b1;
    repeat (3) @(negedge clk);
    set_req = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++; if (c_busy - b_busy != 0) begin n_fail++; $display("FAIL glitch_busy got %0d want 0", c_busy - b_busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_set();
    test_clear();
    test_conflict();
`ifndef SR_CMD_DEBOUNCE_EN
    test_back_to_back();
`endif
    test_err();
    test_reset_mid_pulse();
`ifdef SR_CMD_DEBOUNCE_EN
    test_glitch();
`endif
    n_tests++; if (c_sr != 0) begin n_fail++; $display("FAIL S_and_R_overlap got %0d want 0", c_sr); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
